// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers around a blocking data-memory
// handshake (req held until ack, bounded by ACK_TIMEOUT wait cycles).
// Optional feature: define MEM_STAGE_MISALIGN_EN to reject memory entries whose
// address is not word aligned (no access is issued, misalign_o pulses).

module mem_stage #(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        RegWrite_i,
   input  logic        MemToReg_i,
   input  logic        MemWrite_i,
   input  logic [31:0] ALU_Res_i,
   input  logic [31:0] data2_i,
   input  logic [4:0]  RdAddr_i,
   output logic        stall_o,
   output logic        EX_MEM_RegWrite_o,
   output logic [4:0]  EX_MEM_RdAddr_o,
   output logic [31:0] EX_MEM_ALU_Res_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        wb_valid_o,
   output logic        wb_RegWrite_o,
   output logic [4:0]  wb_RdAddr_o,
   output logic [31:0] wb_data_o,
   output logic        err_o,
   output logic        misalign_o
);

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_next;

   // EX/MEM register; r_exm_valid separates a real entry from a flushed bubble
   logic        r_exm_valid;
   logic        r_exm_regwrite;
   logic        r_exm_memtoreg;
   logic        r_exm_memwrite;
   logic [31:0] r_exm_alu;
   logic [31:0] r_exm_data2;
   logic [4:0]  r_exm_rd;

   logic [7:0]  r_cnt;

   // MEM/WB register
   logic        r_wb_valid;
   logic        r_wb_regwrite;
   logic [4:0]  r_wb_rd;
   logic [31:0] r_wb_data;

   logic        r_err;

   logic        w_in_mem;
   logic        w_in_mis;
   logic        w_timeout;
   logic        w_stall;
   logic        w_capture;
   logic        w_start;
   logic        w_exm_mem;

`ifdef MEM_STAGE_MISALIGN_EN
   assign w_in_mis = w_in_mem && (ALU_Res_i[1:0] != 2'b00);
`else
   assign w_in_mis = 1'b0;
`endif

   // Handshake decode: timeout loses to a same-cycle ack, stall is purely combinational
   always_comb begin
      w_in_mem  = !flush_i && (MemToReg_i || MemWrite_i);
      w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_LAST) && !dmem_ack_i;
      w_stall   = (r_state == S_WAIT) && !dmem_ack_i && !w_timeout;
      w_capture = !w_stall;
      w_start   = w_capture && w_in_mem && !w_in_mis;
      w_exm_mem = r_exm_memtoreg || r_exm_memwrite;
   end

   // FSM next state and memory-port drive (port is quiet outside WAIT)
   always_comb begin
      w_state_next = r_state;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = 32'h0;
      dmem_wdata_o = 32'h0;
      if (w_capture) begin
         w_state_next = w_start ? S_WAIT : S_IDLE;
      end
      if (r_state == S_WAIT) begin
         dmem_req_o   = 1'b1;
         dmem_we_o    = r_exm_memwrite;
         dmem_addr_o  = r_exm_alu;
         dmem_wdata_o = r_exm_data2;
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Wait-cycle counter: cleared when an access starts, counts every WAIT cycle
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt <= 8'h0;
      end else if (w_start) begin
         r_cnt <= 8'h0;
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // EX/MEM capture; held while stalled so address and wdata stay stable
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_exm_valid    <= 1'b0;
         r_exm_regwrite <= 1'b0;
         r_exm_memtoreg <= 1'b0;
         r_exm_memwrite <= 1'b0;
         r_exm_alu      <= 32'h0;
         r_exm_data2    <= 32'h0;
         r_exm_rd       <= 5'h0;
      end else if (w_capture) begin
         if (flush_i) begin
            r_exm_valid    <= 1'b0;
            r_exm_regwrite <= 1'b0;
            r_exm_memtoreg <= 1'b0;
            r_exm_memwrite <= 1'b0;
            r_exm_alu      <= 32'h0;
            r_exm_data2    <= 32'h0;
            r_exm_rd       <= 5'h0;
         end else begin
            r_exm_valid    <= 1'b1;
            r_exm_regwrite <= RegWrite_i;
            r_exm_memtoreg <= MemToReg_i;
            r_exm_memwrite <= MemWrite_i;
            r_exm_alu      <= ALU_Res_i;
            r_exm_data2    <= data2_i;
            r_exm_rd       <= RdAddr_i;
         end
      end
   end

   // MEM/WB write: ALU results pass straight through, memory results land on ack,
   // every other edge (waiting, timeout, rejected access, bubble) writes a bubble
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wb_valid    <= 1'b0;
         r_wb_regwrite <= 1'b0;
         r_wb_rd       <= 5'h0;
         r_wb_data     <= 32'h0;
      end else if ((r_state == S_WAIT) && dmem_ack_i) begin
         r_wb_valid    <= 1'b1;
         r_wb_regwrite <= r_exm_memtoreg ? r_exm_regwrite : 1'b0;
         r_wb_rd       <= r_exm_rd;
         r_wb_data     <= r_exm_memtoreg ? dmem_rdata_i : r_exm_alu;
      end else if ((r_state == S_IDLE) && r_exm_valid && !w_exm_mem) begin
         r_wb_valid    <= 1'b1;
         r_wb_regwrite <= r_exm_regwrite;
         r_wb_rd       <= r_exm_rd;
         r_wb_data     <= r_exm_alu;
      end else begin
         r_wb_valid    <= 1'b0;
         r_wb_regwrite <= 1'b0;
         r_wb_rd       <= 5'h0;
         r_wb_data     <= 32'h0;
      end
   end

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end
   end

`ifdef MEM_STAGE_MISALIGN_EN
   logic r_mis;

   // One-cycle pulse for each misaligned memory entry captured
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mis <= 1'b0;
      end else begin
         r_mis <= w_capture && w_in_mis;
      end
   end

   assign misalign_o = r_mis;
`else
   assign misalign_o = 1'b0;
`endif

   assign stall_o           = w_stall;
   assign EX_MEM_RegWrite_o = r_exm_regwrite;
   assign EX_MEM_RdAddr_o   = r_exm_rd;
   assign EX_MEM_ALU_Res_o  = r_exm_alu;
   assign wb_valid_o        = r_wb_valid;
   assign wb_RegWrite_o     = r_wb_regwrite;
   assign wb_RdAddr_o       = r_wb_rd;
   assign wb_data_o         = r_wb_data;
   assign err_o             = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table, hand-written handshake sequences and a randomized
// instruction stream checked against a transaction-level model of mem_stage.

module tb_mem_stage;

   localparam int TMO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b1;
   logic        RegWrite_i = 1'b0;
   logic        MemToReg_i = 1'b0;
   logic        MemWrite_i = 1'b0;
   logic [31:0] ALU_Res_i = 32'h0;
   logic [31:0] data2_i = 32'h0;
   logic [4:0]  RdAddr_i = 5'h0;
   logic        dmem_ack_i = 1'b0;
   logic [31:0] dmem_rdata_i = 32'h0;
   logic        stall_o;
   logic        EX_MEM_RegWrite_o;
   logic [4:0]  EX_MEM_RdAddr_o;
   logic [31:0] EX_MEM_ALU_Res_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic        wb_valid_o;
   logic        wb_RegWrite_o;
   logic [4:0]  wb_RdAddr_o;
   logic [31:0] wb_data_o;
   logic        err_o;
   logic        misalign_o;

   mem_stage #(.ACK_TIMEOUT(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemWrite_i(MemWrite_i),
      .ALU_Res_i(ALU_Res_i), .data2_i(data2_i), .RdAddr_i(RdAddr_i),
      .stall_o(stall_o),
      .EX_MEM_RegWrite_o(EX_MEM_RegWrite_o), .EX_MEM_RdAddr_o(EX_MEM_RdAddr_o),
      .EX_MEM_ALU_Res_o(EX_MEM_ALU_Res_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
      .wb_valid_o(wb_valid_o), .wb_RegWrite_o(wb_RegWrite_o), .wb_RdAddr_o(wb_RdAddr_o),
      .wb_data_o(wb_data_o), .err_o(err_o), .misalign_o(misalign_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        flush;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic        exp_tap_rw;
      logic [4:0]  exp_tap_rd;
      logic [31:0] exp_tap_alu;
      logic        exp_wb_v;
      logic [4:0]  exp_wb_rd;
      logic [31:0] exp_wb_data;
   } vec_t;

   typedef struct {
      logic        flush;
      logic        rw;
      logic        m2r;
      logic        mw;
      logic [31:0] alu;
      logic [31:0] d2;
      logic [4:0]  rd;
   } ins_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        we;
      int          lat;
   } acc_t;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        is_store;
   } wb_t;

   vec_t vt[6];
   ins_t ins_q[$];
   acc_t acc_q[$];
   wb_t  exp_q[$];
   wb_t  obs_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic f, input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd);
      flush_i = f; RegWrite_i = rw; MemToReg_i = m2r; MemWrite_i = mw;
      ALU_Res_i = alu; data2_i = d2; RdAddr_i = rd;
   endtask

   task automatic set_idle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      set_idle();
      dmem_ack_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   function automatic vec_t mk(input logic f, input logic [4:0] rd, input logic [31:0] alu,
                               input logic trw, input logic [4:0] trd, input logic [31:0] talu,
                               input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
      vec_t v;
      v.flush = f; v.rd = rd; v.alu = alu;
      v.exp_tap_rw = trw; v.exp_tap_rd = trd; v.exp_tap_alu = talu;
      v.exp_wb_v = wv; v.exp_wb_rd = wrd; v.exp_wb_data = wd;
      return v;
   endfunction

   initial begin
      int n_ins;
      int exp_stall, exp_req, obs_stall, obs_req;
      int idx, wcnt, drain, cyc, n;
      logic exp_err;

      // ---------------- reset state ----------------
      #1;
      chk("rst_req", dmem_req_o, 1'b0);
      chk("rst_wb_valid", wb_valid_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_tap_alu", EX_MEM_ALU_Res_o, 32'h0);
      chk("rst_misalign", misalign_o, 1'b0);

      // ---------------- table: ALU/flush stream ----------------
      vt[0] = mk(1'b0, 5'd5,  32'h0000_00AA, 1'b1, 5'd5,  32'h0000_00AA, 1'b0, 5'd0,  32'h0);
      vt[1] = mk(1'b0, 5'd7,  32'h1234_5678, 1'b1, 5'd7,  32'h1234_5678, 1'b1, 5'd5,  32'h0000_00AA);
      vt[2] = mk(1'b1, 5'd9,  32'h0000_FFFF, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h1234_5678);
      vt[3] = mk(1'b0, 5'd3,  32'h0000_CAFE, 1'b1, 5'd3,  32'h0000_CAFE, 1'b0, 5'd0,  32'h0);
      vt[4] = mk(1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd3,  32'h0000_CAFE);
      vt[5] = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h0,         1'b1, 5'd31, 32'hFFFF_FFFF);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         set_in(vt[i].flush, 1'b1, 1'b0, 1'b0, vt[i].alu, 32'h0, vt[i].rd);
         @(posedge clk_i);
         #1;
         chk("tbl_tap_rw", EX_MEM_RegWrite_o, vt[i].exp_tap_rw);
         if (!vt[i].flush) begin
            chk("tbl_tap_rd", EX_MEM_RdAddr_o, vt[i].exp_tap_rd);
            chk("tbl_tap_alu", EX_MEM_ALU_Res_o, vt[i].exp_tap_alu);
         end
         chk("tbl_wb_valid", wb_valid_o, vt[i].exp_wb_v);
         if (vt[i].exp_wb_v) begin
            chk("tbl_wb_rd", wb_RdAddr_o, vt[i].exp_wb_rd);
            chk("tbl_wb_data", wb_data_o, vt[i].exp_wb_data);
            chk("tbl_wb_rw", wb_RegWrite_o, 1'b1);
         end
         chk("tbl_stall", stall_o, 1'b0);
      end

      // ---------------- load, ack after 3 wait cycles, flush while stalled ----------------
      do_reset();
      @(negedge clk_i);
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd4);
      dmem_ack_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         set_in(c == 1, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd6);
         #1;
         chk("ld_req", dmem_req_o, 1'b1);
         chk("ld_addr", dmem_addr_o, 32'h100);
         chk("ld_we", dmem_we_o, 1'b0);
         chk("ld_stall", stall_o, 1'b1);
         chk("ld_bubble", wb_valid_o, 1'b0);
      end
      @(negedge clk_i);
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd6);
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'hDEAD_BEEF;
      #1;
      chk("ld_ack_stall", stall_o, 1'b0);
      chk("ld_ack_req", dmem_req_o, 1'b1);
      chk("ld_ack_bubble", wb_valid_o, 1'b0);
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
      set_idle();
      #1;
      chk("ld_wb_valid", wb_valid_o, 1'b1);
      chk("ld_wb_data", wb_data_o, 32'hDEAD_BEEF);
      chk("ld_wb_rd", wb_RdAddr_o, 5'd4);
      chk("ld_wb_rw", wb_RegWrite_o, 1'b1);
      chk("ld_done_req", dmem_req_o, 1'b0);
      chk("ld_next_tap_rd", EX_MEM_RdAddr_o, 5'd6);
      @(negedge clk_i);
      #1;
      chk("ld_next_wb_data", wb_data_o, 32'h55);
      chk("ld_next_wb_rd", wb_RdAddr_o, 5'd6);

      // ---------------- store with ack on the first request cycle ----------------
      do_reset();
      @(negedge clk_i);
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 32'h1234, 5'd2);
      @(negedge clk_i);
      set_idle();
      dmem_ack_i = 1'b1;
      #1;
      chk("st_req", dmem_req_o, 1'b1);
      chk("st_we", dmem_we_o, 1'b1);
      chk("st_addr", dmem_addr_o, 32'h104);
      chk("st_wdata", dmem_wdata_o, 32'h1234);
      chk("st_stall", stall_o, 1'b0);
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
      #1;
      chk("st_wb_valid", wb_valid_o, 1'b1);
      chk("st_wb_rw", wb_RegWrite_o, 1'b0);
      chk("st_req_drop", dmem_req_o, 1'b0);

      // ---------------- load that never gets an ack ----------------
      do_reset();
      @(negedge clk_i);
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd8);
      for (int c = 0; c < TMO; c++) begin
         @(negedge clk_i);
         set_idle();
         dmem_ack_i = 1'b0;
         #1;
         chk("to_req", dmem_req_o, 1'b1);
         chk("to_stall", stall_o, (c < TMO - 1) ? 1'b1 : 1'b0);
         chk("to_err_early", err_o, 1'b0);
      end
      @(negedge clk_i);
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'h77;
      #1;
      chk("to_req_drop", dmem_req_o, 1'b0);
      chk("to_err", err_o, 1'b1);
      chk("to_wb_valid", wb_valid_o, 1'b0);
      chk("to_stall_low", stall_o, 1'b0);
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
      #1;
      chk("idle_ack_wb", wb_valid_o, 1'b0);
      chk("idle_ack_req", dmem_req_o, 1'b0);
      chk("to_err_sticky", err_o, 1'b1);

      // ---------------- reset pulse in the middle of WAIT ----------------
      @(negedge clk_i);
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9);
      @(negedge clk_i);
      set_idle();
      #1;
      chk("mr_req_before", dmem_req_o, 1'b1);
      #2;
      rst_i = 1'b0;
      #1;
      chk("mr_req", dmem_req_o, 1'b0);
      chk("mr_addr", dmem_addr_o, 32'h0);
      chk("mr_err", err_o, 1'b0);
      chk("mr_wb_valid", wb_valid_o, 1'b0);
      chk("mr_tap_alu", EX_MEM_ALU_Res_o, 32'h0);
      chk("mr_stall", stall_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      #1;
      chk("mr_idle_req", dmem_req_o, 1'b0);
      chk("mr_idle_wb", wb_valid_o, 1'b0);

      // ---------------- misaligned load ----------------
      do_reset();
      @(negedge clk_i);
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd3);
`ifdef MEM_STAGE_MISALIGN_EN
      @(negedge clk_i);
      set_idle();
      #1;
      chk("mis_req", dmem_req_o, 1'b0);
      chk("mis_pulse", misalign_o, 1'b1);
      chk("mis_stall", stall_o, 1'b0);
      @(negedge clk_i);
      #1;
      chk("mis_pulse_end", misalign_o, 1'b0);
      chk("mis_wb_valid", wb_valid_o, 1'b0);
      chk("mis_req_late", dmem_req_o, 1'b0);
`else
      @(negedge clk_i);
      set_idle();
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'hA5;
      #1;
      chk("unal_req", dmem_req_o, 1'b1);
      chk("unal_addr", dmem_addr_o, 32'h102);
      chk("unal_mis", misalign_o, 1'b0);
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
      #1;
      chk("unal_wb_data", wb_data_o, 32'hA5);
      chk("unal_mis2", misalign_o, 1'b0);
`endif

      // ---------------- randomized stream vs transaction model ----------------
      n_ins = 150;
      exp_stall = 0; exp_req = 0; exp_err = 1'b0;
      for (int i = 0; i < n_ins; i++) begin
         ins_t x;
         acc_t a;
         wb_t  w;
         int   t;
         t = $urandom_range(0, 9);
         x.flush = 1'b0; x.rw = 1'b1; x.m2r = 1'b0; x.mw = 1'b0;
         x.alu = $urandom; x.d2 = $urandom; x.rd = 5'($urandom);
         if (t == 5) begin
            x.flush = 1'b1;
         end else if (t >= 6) begin
            x.alu = {x.alu[31:2], 2'b00};
            if (t <= 7) x.m2r = 1'b1;
            else begin x.mw = 1'b1; x.rw = 1'b0; end
            a.addr = x.alu; a.wdata = x.d2; a.rdata = $urandom; a.we = x.mw;
            a.lat = $urandom_range(0, TMO + 1);
            acc_q.push_back(a);
            if (a.lat < TMO) begin
               w.rw = x.rw; w.rd = x.rd; w.data = x.m2r ? a.rdata : x.alu; w.is_store = x.mw;
               exp_q.push_back(w);
               exp_stall += a.lat;
               exp_req += a.lat + 1;
            end else begin
               exp_err = 1'b1;
               exp_stall += TMO - 1;
               exp_req += TMO;
            end
         end else begin
            w.rw = 1'b1; w.rd = x.rd; w.data = x.alu; w.is_store = 1'b0;
            exp_q.push_back(w);
         end
         ins_q.push_back(x);
      end

      do_reset();
      idx = 0; wcnt = 0; drain = 0; cyc = 0; obs_stall = 0; obs_req = 0;
      while ((idx < n_ins || acc_q.size() > 0 || drain < 4) && cyc < 20000) begin
         @(negedge clk_i);
         cyc++;
         if (dmem_req_o) begin
            obs_req++;
            if (acc_q.size() == 0) begin
               chk("rnd_unexpected_req", dmem_req_o, 1'b0);
               dmem_ack_i = 1'b0;
            end else begin
               chk("rnd_addr", dmem_addr_o, acc_q[0].addr);
               chk("rnd_we", dmem_we_o, acc_q[0].we);
               chk("rnd_wdata", dmem_wdata_o, acc_q[0].wdata);
               if (wcnt == acc_q[0].lat) begin
                  dmem_ack_i = 1'b1;
                  dmem_rdata_i = acc_q[0].rdata;
                  void'(acc_q.pop_front());
                  wcnt = 0;
               end else if (wcnt == TMO - 1) begin
                  dmem_ack_i = 1'b0;
                  void'(acc_q.pop_front());
                  wcnt = 0;
               end else begin
                  dmem_ack_i = 1'b0;
                  wcnt++;
               end
            end
         end else begin
            dmem_ack_i = ($urandom_range(0, 3) == 0);
            dmem_rdata_i = $urandom;
         end
         if (idx < n_ins) begin
            set_in(ins_q[idx].flush, ins_q[idx].rw, ins_q[idx].m2r, ins_q[idx].mw,
                   ins_q[idx].alu, ins_q[idx].d2, ins_q[idx].rd);
         end else begin
            set_idle();
         end
         #1;
         if (stall_o) obs_stall++;
         if (wb_valid_o) begin
            wb_t o;
            o.rw = wb_RegWrite_o; o.rd = wb_RdAddr_o; o.data = wb_data_o; o.is_store = 1'b0;
            obs_q.push_back(o);
         end
         if (!stall_o && idx < n_ins) idx++;
         if (idx >= n_ins && acc_q.size() == 0) drain++;
      end
      dmem_ack_i = 1'b0;
      chk("rnd_finished_in_budget", (cyc < 20000) ? 32'd1 : 32'd0, 32'd1);
      chk("rnd_wb_count", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk("rnd_wb_rw", obs_q[i].rw, exp_q[i].rw);
         if (!exp_q[i].is_store) begin
            chk("rnd_wb_rd", obs_q[i].rd, exp_q[i].rd);
            chk("rnd_wb_data", obs_q[i].data, exp_q[i].data);
         end
      end
      chk("rnd_stall_cycles", obs_stall, exp_stall);
      chk("rnd_req_cycles", obs_req, exp_req);
      chk("rnd_err", err_o, exp_err);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, max WAIT cycles before abort (range 1..255).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-003 SHALL have port clk_i  input  1  clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush_i  input  1  capture bubble instead of EX result.
REQ-006 SHALL have ports RegWrite_i, MemToReg_i, MemWrite_i  input  1 each  EX control bits.
REQ-007 SHALL have ports ALU_Res_i  input  32  address/result; data2_i  input  32  store data; RdAddr_i  input  5  dest reg.
REQ-008 SHALL have port stall_o  output  1  upstream hold request.
REQ-009 SHALL have ports EX_MEM_RegWrite_o  output  1; EX_MEM_RdAddr_o  output  5; EX_MEM_ALU_Res_o  output  32  forwarding taps.
REQ-010 SHALL have ports dmem_req_o, dmem_we_o  output  1; dmem_addr_o, dmem_wdata_o  output  32; dmem_ack_i  input  1; dmem_rdata_i  input  32.
REQ-011 SHALL have ports wb_valid_o, wb_RegWrite_o  output  1; wb_RdAddr_o  output  5; wb_data_o  output  32.
REQ-012 SHALL have ports err_o  output  1  sticky timeout; misalign_o  output  1  misalign pulse.

Function
REQ-013 EX/MEM register SHALL capture inputs on every edge where stall_o=0; with flush_i=1 it captures a bubble (all control bits 0).
REQ-014 stall_o SHALL equal (state==WAIT) && !dmem_ack_i && !timeout, combinational.
REQ-015 FSM states IDLE, WAIT; IDLE->WAIT on the edge capturing a non-bubble entry with MemToReg_i|MemWrite_i; WAIT->IDLE on ack or timeout.
REQ-016 In WAIT: dmem_req_o=1, dmem_we_o=EX/MEM MemWrite, dmem_addr_o=EX/MEM ALU_Res, dmem_wdata_o=EX/MEM data2; in IDLE all dmem outputs 0.
REQ-017 Address and wdata SHALL remain stable while dmem_req_o=1; flush_i SHALL NOT abort an outstanding access.
REQ-018 Non-memory entry SHALL reach MEM/WB exactly one edge after EX/MEM capture, wb_data_o=ALU_Res.
REQ-019 Load SHALL update MEM/WB on the ack edge with wb_data_o=dmem_rdata_i; store SHALL write wb_valid_o=1, wb_RegWrite_o=0 on the ack edge.
REQ-020 Each WAIT edge without ack or timeout SHALL write a bubble (wb_valid_o=0) to MEM/WB.
REQ-021 8-bit counter SHALL clear on WAIT entry and increment per WAIT cycle; timeout = count==ACK_TIMEOUT-1 && !ack.
REQ-022 On timeout: req dropped next cycle, MEM/WB bubble, err_o set until reset, state IDLE, stall released same cycle.
REQ-023 Ack arriving with timeout in the same cycle SHALL count as ack (no error).
REQ-024 Ack in IDLE SHALL be ignored.
REQ-025 Forwarding taps SHALL reflect EX/MEM register contents unconditionally.

Reset
REQ-026 rst_i low SHALL immediately force IDLE, counter 0, EX/MEM and MEM/WB to bubble (all fields 0), err_o=0, misalign_o=0, all dmem outputs 0.
REQ-027 Reset asserted during WAIT SHALL drop dmem_req_o asynchronously; no MEM/WB write follows.

Configuration
REQ-028 With MEM_STAGE_MISALIGN_EN defined, a memory entry with ALU_Res[1:0]!=0 SHALL NOT enter WAIT, SHALL pulse misalign_o for one cycle and send a bubble to MEM/WB.
REQ-029 Without MEM_STAGE_MISALIGN_EN, misalign_o SHALL be tied 0 and addresses pass unchecked.

Verification
REQ-030 ALU entry Rd=5, res=0x0000_00AA -> wb_valid_o=1, wb_data_o=0xAA, wb_RdAddr_o=5 one edge later; stall_o never 1.
REQ-031 Load addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stall_o high 3 cycles, 3 bubbles, then wb_data_o=0xDEADBEEF.
REQ-032 Store addr 0x104 data 0x1234, ack same cycle as first req -> dmem_we_o=1, no stall-induced hold, wb_RegWrite_o=0.
REQ-033 Load with no ack, ACK_TIMEOUT=4 -> req high 4 cycles, err_o=1 thereafter, wb_valid_o stays 0, stall_o low after 4 cycles.
REQ-034 Reset pulse mid-WAIT -> dmem_req_o=0 immediately, all outputs 0, FSM IDLE after release.
REQ-035 MEM_STAGE_MISALIGN_EN defined, load addr 0x102 -> no req, misalign_o one-cycle pulse, wb_valid_o=0.
